// File: rtl/simon_core_arbiter.sv
// Round-robin arbiter that shares one iterative SIMON cipher core between two requesters.
// Each accepted request is latched, run on the core for ROUND_CYCLES cycles, then held as a response.
module simon_core_arbiter #(
  parameter int ROUND_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req0_plaintext,
  input  logic [31:0] req1_plaintext,
  input  logic [63:0] req0_key,
  input  logic [63:0] req1_key,
  output logic [1:0]  resp_valid,
  input  logic [1:0]  resp_ready,
  output logic [31:0] resp_ciphertext,
  output logic        core_load,
  output logic [31:0] core_plaintext,
  output logic [63:0] core_key,
  output logic [4:0]  core_count,
  input  logic [31:0] core_ciphertext,
  output logic        busy,
  output logic        grant_id
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [4:0] LAST_COUNT = 5'(ROUND_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic        lastGrant_q, lastGrant_d;
  logic        grantId_q, grantId_d;
  logic [31:0] ptext_q, ptext_d;
  logic [63:0] key_q, key_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] result_q, result_d;
  logic        anyReq;
  logic        sel;

  // On a tie the requester that was not served last wins.
  always_comb begin
    anyReq = |req_valid;
    if (req_valid == 2'b11) sel = ~lastGrant_q;
    else                    sel = req_valid[1];
  end

  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    grantId_d   = grantId_q;
    ptext_d     = ptext_q;
    key_d       = key_q;
    count_d     = count_q;
    result_d    = result_q;
    case (state_q)
      IDLE: begin
        if (anyReq) begin
          ptext_d   = sel ? req1_plaintext : req0_plaintext;
          key_d     = sel ? req1_key : req0_key;
          grantId_d = sel;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        count_d = 5'd0;
        state_d = RUN;
      end
      RUN: begin
        if (count_q == LAST_COUNT) begin
          result_d = core_ciphertext;
          count_d  = 5'd0;
          state_d  = RESP;
        end else begin
          count_d = count_q + 5'd1;
        end
      end
      RESP: begin
        if (resp_ready[grantId_q]) begin
          lastGrant_d = grantId_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      grantId_q   <= 1'b0;
      ptext_q     <= '0;
      key_q       <= '0;
      count_q     <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      grantId_q   <= grantId_d;
      ptext_q     <= ptext_d;
      key_q       <= key_d;
      count_q     <= count_d;
      result_q    <= result_d;
    end
  end

  always_comb begin
    req_ready       = (state_q == IDLE && anyReq) ? (sel ? 2'b10 : 2'b01) : 2'b00;
    resp_valid      = (state_q == RESP) ? (grantId_q ? 2'b10 : 2'b01) : 2'b00;
    resp_ciphertext = (state_q == RESP) ? result_q : 32'd0;
    core_load       = (state_q == LOAD);
    core_count      = (state_q == RUN) ? count_q : 5'd0;
    core_plaintext  = ptext_q;
    core_key        = key_q;
    busy            = (state_q != IDLE);
    grant_id        = grantId_q;
  end

endmodule

// File: doc/simon_core_arbiter.md
SIMON_CORE_ARBITER -- requirements
Module: simon_core_arbiter

Interface
REQ-001 SHALL have parameter: ROUND_CYCLES, default 4, core cycles from first RUN cycle to valid core_ciphertext; legal range 1..31.
REQ-002 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: req_valid  input  2  per-requester encryption request (bit i = requester i).
REQ-005 SHALL have port: req_ready  output  2  per-requester request accept.
REQ-006 SHALL have port: req0_plaintext, req1_plaintext  input  32 each  plaintext block.
REQ-007 SHALL have port: req0_key, req1_key  input  64 each  cipher key.
REQ-008 SHALL have port: resp_valid  output  2  per-requester result valid.
REQ-009 SHALL have port: resp_ready  input  2  per-requester result accept.
REQ-010 SHALL have port: resp_ciphertext  output  32  shared result bus.
REQ-011 SHALL have ports: core_load output 1, core_plaintext output 32, core_key output 64, core_count output 5, core_ciphertext input 32  shared cipher-core interface.
REQ-012 SHALL have ports: busy output 1 (state != IDLE); grant_id output 1 (current/last granted requester).

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, RUN, RESP.
REQ-014 IDLE: with no req_valid bits set, stay IDLE; req_ready = 0.
REQ-015 IDLE with any req_valid: select grant g; req_ready[g] = 1 combinationally in the same cycle; req_ready of the other bit = 0.
REQ-016 Grant selection is round-robin: one valid -> that requester; both valid -> requester != last_grant.
REQ-017 On the accept edge: latch req<g>_plaintext and req<g>_key into internal registers; set grant_id = g; go to LOAD.
REQ-018 LOAD, one cycle: core_load = 1; core_plaintext/core_key = latched registers; core_count = 0; then go to RUN.
REQ-019 RUN: core_count starts at 0 and increments by 1 per cycle. When core_count == ROUND_CYCLES-1, capture core_ciphertext into the result register on that edge and go to RESP.
REQ-020 core_plaintext and core_key SHALL hold latched values in LOAD, RUN and RESP; core_count = 0 outside RUN.
REQ-021 RESP: resp_valid[g] = 1; resp_ciphertext = result register; the other resp_valid bit = 0.
REQ-022 RESP: stay in RESP until resp_ready[g] = 1. On that edge, set last_grant = g and go to IDLE. resp_ready of the non-granted bit is ignored.
REQ-023 Outside RESP: resp_valid = 0 and resp_ciphertext = 0.
REQ-024 Latency: accept in cycle 0, LOAD in cycle 1, RUN in cycles 2..1+ROUND_CYCLES, resp_valid first high in cycle 2+ROUND_CYCLES.
REQ-025 Back-to-back: after a RESP->IDLE transition, the earliest next accept is the following cycle (one IDLE cycle minimum).
REQ-026 Changes to req_valid or request data after accept SHALL NOT affect the operation in flight.
REQ-027 A requester deasserting req_valid while not granted is legal; no request is lost or duplicated.
REQ-028 core_count arithmetic is 5-bit; it never wraps, because ROUND_CYCLES <= 31.

Reset
REQ-029 While rst = 1 at a clock edge, next state SHALL be IDLE, irrespective of current state (including mid-RUN or RESP).
REQ-030 Reset values: req_ready = 0, resp_valid = 0, resp_ciphertext = 0, core_load = 0, core_count = 0, core_plaintext = 0, core_key = 0, busy = 0, grant_id = 0.
REQ-031 Reset SHALL set last_grant = 1, so requester 0 wins the first tie.
REQ-032 An in-flight operation aborted by reset SHALL produce no response after reset.

Verification
REQ-033 Single request: req_valid = 01, plaintext 0x65656877, key 0x1918111009080100, ROUND_CYCLES = 4, core model returns 0xC69BE9BB -> req_ready[0] in cycle 0; core_load in cycle 1; core_count 0,1,2,3 in cycles 2-5; resp_valid = 01 with 0xC69BE9BB in cycle 6.
REQ-034 Tie after reset: req_valid = 11 -> requester 0 granted first. After its response, with both still valid -> requester 1 granted; third grant goes to requester 0.
REQ-035 Response backpressure: resp_ready[g] held 0 for 5 cycles -> resp_valid and resp_ciphertext held stable; no new req_ready during the stall; IDLE follows the cycle after resp_ready rises.
REQ-036 Input change after accept: req0_plaintext changed during RUN -> core_plaintext unchanged and result matches the originally latched block.
REQ-037 Reset mid-RUN: rst pulsed with core_count = 2 -> next cycle all outputs at reset values and busy = 0; no resp_valid follows; the next request behaves as after power-up.
REQ-038 Wrong-bit ready: resp_ready = 10 while granting requester 0 -> remain in RESP with resp_valid = 01.
